// File: rtl/icache_pkg.sv
// Shared types for the direct-mapped instruction cache: address split, frame
// layout and fill-FSM states for the default 16-set geometry.
package icache_pkg;

    localparam int IIDX_W = 4;
    localparam int ITAG_W = 30 - IIDX_W;

    typedef struct packed {
        logic [ITAG_W-1:0] tag;
        logic [IIDX_W-1:0] idx;
        logic [1:0]        bytoff;
    } icachef_t;

    typedef struct packed {
        logic              valid;
        logic [ITAG_W-1:0] tag;
        logic [31:0]       data;
    } icache_frame_t;

    typedef enum logic {
        IDLE,
        MISS
    } icache_state_t;

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-side signals of the instruction cache. The cache is
// the slave; the datapath/controller environment is the master.
interface icache_if;

    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;

    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    modport master (
        output imemREN, imemaddr, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );

    modport slave (
        input  imemREN, imemaddr, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

endinterface

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with one-word frames. Hits are
// combinational; a miss runs a two-state fill and replays as a hit.
module icache
    import icache_pkg::*;
#(
    parameter int SETS = 2 ** IIDX_W
) (
    input logic     CLK,
    input logic     nRST,
    icache_if.slave bus
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;

    icache_state_t state, next_state;

    logic [SETS-1:0]  valid;
    logic [TAG_W-1:0] tags [SETS];
    logic [31:0]      data [SETS];

    // Word address of the outstanding miss; iaddr is built from this only.
    logic [29:0]      miss_word;

    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic [IDX_W-1:0] miss_idx;
    logic             hit;
    logic             fill;
    logic             unused_byteoff;

    assign req_tag        = bus.imemaddr[31:IDX_W+2];
    assign req_idx        = bus.imemaddr[IDX_W+1:2];
    assign miss_idx       = miss_word[IDX_W-1:0];
    assign unused_byteoff = ^bus.imemaddr[1:0];

    assign hit  = bus.imemREN && valid[req_idx] && (tags[req_idx] == req_tag)
                  && (state == IDLE);
    assign fill = (state == MISS) && !bus.iwait;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state     <= IDLE;
            valid     <= '0;
            miss_word <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && bus.imemREN && !hit) begin
                miss_word <= bus.imemaddr[31:2];
            end
            if (fill) begin
                valid[miss_idx] <= 1'b1;
            end
        end
    end

    // NOTE: only the valid bits need reset; tag and data storage is gated by
    // valid, so leaving it unreset keeps the arrays as plain RAM.
    always_ff @(posedge CLK) begin
        if (fill) begin
            tags[miss_idx] <= miss_word[29:IDX_W];
            data[miss_idx] <= bus.iload;
        end
    end

    // NOTE: every output gets a default before the case so no path can
    // leave a value held, which would infer a latch.
    always_comb begin
        next_state   = state;
        bus.ihit     = 1'b0;
        bus.imemload = '0;
        bus.iREN     = 1'b0;
        bus.iaddr    = '0;

        case (state)
            IDLE: begin
                bus.ihit = hit;
                if (hit) begin
                    bus.imemload = data[req_idx];
                end else if (bus.imemREN) begin
                    next_state = MISS;
                end
            end
            MISS: begin
                bus.iREN  = 1'b1;
                bus.iaddr = {miss_word, 2'b00};
                if (!bus.iwait) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed test-plan scenarios followed by
// random fetches, all compared against a set-indexed residency model.
module tb_icache;

    localparam int SETS = 16;

    logic CLK = 1'b0;
    logic nRST;

    icache_if bus ();

    icache #(.SETS(SETS)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Model: backing memory by word address, and which word each set holds.
    logic [31:0] mem [logic [29:0]];
    logic [29:0] resident_word [SETS];
    bit          resident_ok   [SETS];

    function automatic logic [31:0] mem_at(input logic [29:0] w);
        if (!mem.exists(w)) mem[w] = $urandom;
        return mem[w];
    endfunction

    function automatic bit model_hit(input logic [31:0] addr);
        int s = int'(addr[31:2] % SETS);
        return resident_ok[s] && resident_word[s] == addr[31:2];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < SETS; i++) resident_ok[i] = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One fetch of addr; on a miss memory is busy for 'busy' cycles, and with
    // 'drop' the request is withdrawn and the address scrambled during MISS.
    task automatic fetch(input logic [31:0] addr, input int busy, input bit drop);
        logic [29:0] w = addr[31:2];
        logic [31:0] word_addr = {addr[31:2], 2'b00};
        int s = int'(w % SETS);
        @(negedge CLK);
        bus.imemREN  = 1'b1;
        bus.imemaddr = addr;
        bus.iwait    = 1'b1;
        #1;
        if (model_hit(addr)) begin
            check("hit_ihit", {31'b0, bus.ihit}, 32'd1);
            check("hit_data", bus.imemload, mem_at(w));
            check("hit_iren", {31'b0, bus.iREN}, 32'd0);
            check("hit_iaddr", bus.iaddr, 32'd0);
            return;
        end
        check("miss_ihit", {31'b0, bus.ihit}, 32'd0);
        check("miss_load", bus.imemload, 32'd0);
        check("miss_iren_t", {31'b0, bus.iREN}, 32'd0);
        for (int k = 0; k <= busy; k++) begin
            @(negedge CLK);
            if (drop) begin
                bus.imemREN  = 1'b0;
                bus.imemaddr = $urandom;
            end
            bus.iwait = (k < busy);
            bus.iload = (k < busy) ? $urandom : mem_at(w);
            #1;
            check("fill_iren", {31'b0, bus.iREN}, 32'd1);
            check("fill_iaddr", bus.iaddr, word_addr);
            check("fill_ihit", {31'b0, bus.ihit}, 32'd0);
        end
        resident_ok[s]   = 1'b1;
        resident_word[s] = w;
        @(negedge CLK);
        bus.iwait = 1'b1;
        bus.iload = $urandom;
        if (!drop) begin
            bus.imemaddr = addr;
        end
        #1;
        check("replay_iren", {31'b0, bus.iREN}, 32'd0);
        check("replay_iaddr", bus.iaddr, 32'd0);
        if (drop) begin
            check("drop_ihit", {31'b0, bus.ihit}, 32'd0);
        end else begin
            check("replay_ihit", {31'b0, bus.ihit}, 32'd1);
            check("replay_data", bus.imemload, mem_at(w));
        end
    endtask

    initial begin
        nRST         = 1'b0;
        bus.imemREN  = 1'b0;
        bus.imemaddr = '0;
        bus.iwait    = 1'b1;
        bus.iload    = '0;
        model_clear();
        mem[30'h0]  = 32'h0050_0093;
        mem[30'h10] = 32'hDEAD_BEEF;
        mem[30'h1]  = 32'h0010_0113;

        repeat (2) @(negedge CLK);
        nRST = 1'b1;
        #1;
        check("rst_ihit", {31'b0, bus.ihit}, 32'd0);
        check("rst_load", bus.imemload, 32'd0);
        check("rst_iren", {31'b0, bus.iREN}, 32'd0);
        check("rst_iaddr", bus.iaddr, 32'd0);

        // Cold miss with two busy cycles, then warm hit.
        fetch(32'h0, 2, 1'b0);
        fetch(32'h0, 0, 1'b0);

        // Conflict on set 0, then set 1, then both resident.
        fetch(32'h40, 1, 1'b0);
        fetch(32'h0, 0, 1'b0);
        fetch(32'h4, 3, 1'b0);
        fetch(32'h0, 0, 1'b0);
        fetch(32'h4, 0, 1'b0);
        fetch(32'h6, 0, 1'b0);

        // Request withdrawn during MISS: fill still lands.
        fetch(32'h8C, 2, 1'b1);
        fetch(32'h8C, 0, 1'b0);

        // Reset during MISS discards the fill and all resident frames.
        @(negedge CLK);
        bus.imemREN  = 1'b1;
        bus.imemaddr = 32'h108;
        bus.iwait    = 1'b1;
        #1;
        check("rmm_detect", {31'b0, bus.ihit}, 32'd0);
        @(negedge CLK);
        #1;
        check("rmm_iren", {31'b0, bus.iREN}, 32'd1);
        @(negedge CLK);
        nRST      = 1'b0;
        bus.iwait = 1'b0;
        bus.iload = 32'h1234_5678;
        @(negedge CLK);
        nRST        = 1'b1;
        bus.imemREN = 1'b0;
        bus.iwait   = 1'b1;
        #1;
        check("rmm_iren_after", {31'b0, bus.iREN}, 32'd0);
        check("rmm_ihit_after", {31'b0, bus.ihit}, 32'd0);
        check("rmm_iaddr_after", bus.iaddr, 32'd0);
        model_clear();
        fetch(32'h0, 1, 1'b0);

        // Random fetches over a small address window to force reuse/conflicts.
        for (int n = 0; n < 80; n++) begin
            logic [31:0] a;
            a = ({30'b0, 2'($urandom_range(0, 3))} << 6)
              | ({28'b0, 4'($urandom_range(0, 15))} << 2)
              | {30'b0, 2'($urandom_range(0, 3))};
            fetch(a, $urandom_range(0, 3), ($urandom_range(0, 5) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
